// File: rtl/uart_pkg.sv
// Shared types and default constants for the I/O-mapped UART transmitter.
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO ahead of the serialiser; accepts a push while full when a pop happens
// on the same edge. Storage is not reset, only pointers and count.
module byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io_uart_tx.sv
// I/O-mapped 8N1 UART transmitter: write strobe feeds a byte FIFO, an FSM
// serialises LSB first with back-to-back frames and a sticky drop flag.
module io_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic        TX,
    output logic        Busy,
    output logic        Full,
    output logic        Overflow
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             baud_end, pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_wd_hi;

    assign unused_wd_hi = ^WD[31:8];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (WE),
        .wdata (WD[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // TX is registered from the next state so the line never glitches.
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end

        overflow_d = overflow_q | (WE & fifo_full & ~pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    assign TX       = tx_q;
    assign Busy     = (state_q != S_IDLE) | (fifo_count != '0);
    assign Full     = fifo_full;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: frame-level reference model, per-cycle output compare,
// mid-bit deserialising scoreboard and directed literal checks.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WE  = 1'b0;
    logic [31:0] WD  = 32'h0;
    logic        TX, Busy, Full, Overflow;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WE       (WE),
        .WD       (WD),
        .TX       (TX),
        .Busy     (Busy),
        .Full     (Full),
        .Overflow (Overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the position inside the current frame.
    logic [7:0] mq[$];
    logic [7:0] acc_log[$];
    bit         m_act = 1'b0;
    int         m_t   = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge CLK or posedge RST) begin : model_step
        bit m_full, m_pop, m_acc;
        if (RST) begin
            mq.delete();
            acc_log.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && (!m_act || m_t == FRAME - 1);
            m_acc  = WE && (!m_full || m_pop);
            if (WE && m_full && !m_pop) m_ovf = 1'b1;
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end else if (m_act) begin
                if (m_t == FRAME - 1) m_act = 1'b0;
                else m_t++;
            end
            if (m_acc) begin
                mq.push_back(WD[7:0]);
                acc_log.push_back(WD[7:0]);
            end
        end
    end

    function automatic logic m_tx();
        if (!m_act) return 1'b1;
        if (m_t < CPB) return 1'b0;
        if (m_t < 9 * CPB) return m_cur[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    always @(negedge CLK) begin
        check("tx", TX, m_tx());
        check("busy", Busy, m_act || (mq.size() != 0));
        check("full", Full, mq.size() == DEPTH);
        check("overflow", Overflow, m_ovf);
    end

    // Deserialiser: samples the line at the middle of every bit.
    bit         mon_busy = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge CLK) begin
        if (RST) begin
            mon_busy = 1'b0;
            mon_cnt  = 0;
        end else if (!mon_busy) begin
            if (TX == 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB / 2) check("sb_start_bit", TX, 0);
            for (int i = 0; i < 8; i++)
                if (mon_cnt == CPB + CPB * i + CPB / 2) mon_byte[i] = TX;
            if (mon_cnt == 9 * CPB + CPB / 2) begin
                check("sb_stop_bit", TX, 1);
                if (acc_log.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_byte: got %0h expected no frame (log empty) at t=%0t", mon_byte, $time);
                end else begin
                    check("sb_byte", mon_byte, acc_log.pop_front());
                end
            end
            if (mon_cnt == FRAME - 1) mon_busy = 1'b0;
        end
    end
    // Mid-bit sampling above assumes the frame starts one negedge after the pop edge.

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] d);
        WE = 1'b1;
        WD = d;
        @(negedge CLK);
        WE = 1'b0;
        WD = $urandom;
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
    endtask

    logic [9:0] frame55;
    int         drain;

    initial begin
        frame55 = 10'b1010101010;
        cycles(2);
        check("rst_tx", TX, 1);
        check("rst_busy", Busy, 0);
        check("rst_full", Full, 0);
        check("rst_ovf", Overflow, 0);

        // Single frame written on the first edge after reset release.
        #2 RST = 1'b0;
        wr(32'hDEADBE55);
        for (int i = 1; i <= FRAME; i++) begin
            cycles(1);
            check("f55_tx", TX, frame55[(i - 1) / CPB]);
            check("f55_busy_on", Busy, 1);
        end
        cycles(1);
        check("f55_busy_off", Busy, 0);
        check("f55_idle_tx", TX, 1);

        // Two back-to-back frames.
        cycles(3);
        wr(32'h000000A5);
        cycles(2);
        wr(32'h0000003C);
        cycles(37);
        check("b2b_stop", TX, 1);
        cycles(1);
        check("b2b_start", TX, 0);
        check("b2b_busy", Busy, 1);
        cycles(FRAME + 5);

        // Six consecutive writes, one dropped.
        for (int v = 1; v <= 6; v++) begin
            wr(32'(v));
            if (v == 5) begin
                check("burst_full", Full, 1);
                check("burst_ovf_pre", Overflow, 0);
            end
            if (v == 6) begin
                check("burst_ovf", Overflow, 1);
                check("burst_full2", Full, 1);
            end
        end
        cycles(5 * FRAME + 10);
        check("ovf_sticky", Overflow, 1);
        do_reset();
        check("ovf_cleared", Overflow, 0);

        // Write while full on the STOP-to-START pop edge.
        for (int v = 1; v <= 5; v++) wr(32'h11 * v);
        check("pop_full_pre", Full, 1);
        cycles(36);
        check("pop_full_stop", TX, 1);
        wr(32'h00000066);
        check("pop_full_keep", Full, 1);
        check("pop_full_noovf", Overflow, 0);
        check("pop_full_start", TX, 0);
        cycles(5 * FRAME + 10);

        // Reset during the third data bit with two bytes queued.
        wr(32'h77);
        wr(32'h88);
        wr(32'h99);
        cycles(12);
        #2 RST = 1'b1;
        #1;
        check("abort_tx", TX, 1);
        check("abort_busy", Busy, 0);
        check("abort_full", Full, 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        cycles(60);
        check("abort_quiet_busy", Busy, 0);
        check("abort_quiet_tx", TX, 1);

        // Random traffic.
        for (int c = 0; c < 1000; c++) begin
            WE = ($urandom_range(0, 29) == 0) || ((c / 200) % 2 == 1 && $urandom_range(0, 9) == 0);
            WD = $urandom;
            @(negedge CLK);
        end
        WE = 1'b0;
        drain = 0;
        while (Busy && drain < 400) begin
            cycles(1);
            drain++;
        end
        check("drain_done", Busy, 0);
        cycles(2);
        check("log_empty", acc_log.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 868, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter: FIFO_DEPTH, 4, byte entries buffered ahead of the serialiser; power of two, 2..16.
REQ-003 Port: CLK  input  1  single system clock; all state updates on posedge CLK.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: WE  input  1  one-cycle write strobe, the I/O-write enable of the data memory/IO stage.
REQ-006 Port: WD  input  32  write data; only WD[7:0] is transmitted, WD[31:8] is ignored.
REQ-007 Port: TX  output  1  serial line, idle high, 8N1, LSB first.
REQ-008 Port: Busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 Port: Full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-010 Port: Overflow  output  1  sticky; set when a write is dropped.

Function
REQ-011 A write is accepted on a posedge CLK with WE=1 when Full=0, or when Full=1 and a pop occurs on the same edge.
REQ-012 A write with WE=1, Full=1 and no same-edge pop is dropped and sets Overflow on that edge; FIFO contents are unchanged.
REQ-013 The FIFO is first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: TX=1; on an edge with FIFO non-empty, pop the head into the shift register, clear the bit counter, go to START.
REQ-016 START: TX=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: TX = shift register bit 0 for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
REQ-018 STOP: TX=1 for CLKS_PER_BIT cycles; then pop the next byte and go to START if the FIFO is non-empty, else go to IDLE.
REQ-019 Back-to-back frames have no idle gap: the next start bit follows the last stop-bit cycle directly.
REQ-020 Latency: for a write accepted at edge k into an empty FIFO with the FSM in IDLE, the pop occurs at edge k+1 and TX=0 from edge k+1.
REQ-021 The frame length is exactly 10*CLKS_PER_BIT cycles.
REQ-022 The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-023 A simultaneous push and pop at count=FIFO_DEPTH leaves the count unchanged and keeps Full=1.
REQ-024 Busy = (state != IDLE) | (count != 0); Full = (count == FIFO_DEPTH); both are combinational from registers.
REQ-025 Overflow clears only on reset.

Reset
REQ-026 While RST=1, and asynchronously upon its assertion: state=IDLE, TX=1, FIFO count and pointers=0, Busy=0, Full=0, Overflow=0, baud and bit counters=0.
REQ-027 Asserting RST mid-frame aborts the frame immediately, TX returns high, and all buffered bytes are discarded.
REQ-028 A write on the first edge after RST deasserts is accepted normally.

Structure
REQ-029 Package uart_pkg holds the FSM state enum and the default constants for CLKS_PER_BIT and FIFO_DEPTH.
REQ-030 The FIFO is a sub-module named byte_fifo, parameterised by depth, with push/pop/full/empty/count ports and the same CLK/RST scheme.
REQ-031 The serialiser FSM, baud counter and bit counter reside in io_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Single write WD=32'hDEADBE55 at edge k -> TX=0 for edges k+1..k+4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then TX=1 for 4 cycles, then IDLE with Busy=0 at edge k+41.
REQ-033 Write 8'hA5 while in IDLE, then 8'h3C three cycles later -> two contiguous 40-cycle frames with no idle gap, LSB first.
REQ-034 Six consecutive-cycle writes 01..06 during a frame -> Full=1 after the fourth queued byte, one write dropped and Overflow=1, and the transmitted bytes match the accepted writes in order.
REQ-035 Write while Full=1 on the STOP-to-START pop edge -> write accepted, Full stays 1, Overflow stays 0.
REQ-036 Assert RST during the third DATA bit with 2 bytes queued -> TX=1 in the same cycle, Busy=0, and after release no frame is sent until a new write.
REQ-037 Scoreboard: sample TX at each mid-bit and compare the deserialised bytes against the accepted-write log over 1000 random WE/WD cycles.
